// File: rtl/controle_varredura_matriz.sv
// controle_varredura_matriz: row-scan controller for a 5-column LED matrix.
// It steps the row index `contador` once per DIV_ROW clock cycles and drives
// it into the frame decoders. The decoder columns and an active-low one-hot
// row pattern are registered out to the matrix. Frames rotate through
// 0..FRAMES-1, and each frame stays up for DWELL complete scans.
//
// Optional feature: define MATRIZ_BLANK_EN to add a 2-cycle dark BLANK state
// after every row step (anti-ghosting). The row period stays DIV_ROW cycles,
// so DIV_ROW must be at least 3 when this feature is enabled.
module controle_varredura_matriz #(
  parameter int DIV_ROW = 1000,  // clock cycles per row step (>=2)
  parameter int ROWS    = 7,     // rows per frame, 1..8
  parameter int FRAMES  = 4,     // frames in rotation, 2..4
  parameter int DWELL   = 50     // complete scans per frame (>=1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            hold,
  input  logic [4:0]      colunas_in,
  output logic [2:0]      contador,
  output logic [1:0]      quadro_sel,
  output logic [ROWS-1:0] linhas,
  output logic [4:0]      colunas,
  output logic            fim_quadro
);

  localparam int PRE_W = (DIV_ROW > 1) ? $clog2(DIV_ROW) : 1;
  localparam int SCN_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV_ROW - 1);
  localparam logic [2:0]       ROW_LAST   = 3'(ROWS - 1);
  localparam logic [1:0]       FRAME_LAST = 2'(FRAMES - 1);
  localparam logic [SCN_W-1:0] SCAN_LAST  = SCN_W'(DWELL - 1);
  localparam logic [ROWS-1:0]  ROW_ONE    = ROWS'(1);
  localparam logic [ROWS-1:0]  ROWS_DARK  = '1;

`ifdef MATRIZ_BLANK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1
  } state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [PRE_W-1:0] pre_q;
  logic [SCN_W-1:0] scan_q;
  logic             pre_run;
  logic             tick;
  logic [ROWS-1:0]  row_drive;

  // Next state and per-cycle scan controls.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and turn it into a latch.
    state_d   = state_q;
    pre_run   = 1'b0;
    tick      = 1'b0;
    row_drive = ~(ROW_ONE << contador);

    case (state_q)
      IDLE: begin
        if (enable) state_d = SCAN;
      end
      SCAN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          pre_run = 1'b1;
          tick    = (pre_q == PRE_LAST);
`ifdef MATRIZ_BLANK_EN
          if (tick) state_d = BLANK;
`endif
        end
      end
`ifdef MATRIZ_BLANK_EN
      BLANK: begin
        // Entered with the prescaler at 0; leaving when it reads 1 gives
        // exactly two dark cycles while the row period keeps running.
        if (!enable) begin
          state_d = IDLE;
        end else begin
          pre_run = 1'b1;
          if (pre_q == PRE_W'(1)) state_d = SCAN;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Prescaler, row index, dwell count and frame rotation.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q      <= '0;
      contador   <= '0;
      quadro_sel <= '0;
      scan_q     <= '0;
      fim_quadro <= 1'b0;
    end else begin
      fim_quadro <= 1'b0;

      if (!pre_run || pre_q == PRE_LAST) pre_q <= '0;
      else                               pre_q <= pre_q + 1'b1;

      if (tick) begin
        if (contador == ROW_LAST) begin
          contador <= '0;
          if (scan_q == SCAN_LAST && !hold) begin
            scan_q     <= '0;
            quadro_sel <= (quadro_sel == FRAME_LAST) ? 2'd0 : quadro_sel + 1'b1;
            fim_quadro <= 1'b1;
          end else if (scan_q != SCAN_LAST) begin
            // While hold is set, the count parks at the last scan, so the
            // first wrap after release advances the frame.
            scan_q <= scan_q + 1'b1;
          end
        end else begin
          contador <= contador + 1'b1;
        end
      end
    end
  end

  // Registered matrix drive. It follows the state being entered, and the
  // row pattern is built from the current contador (one cycle of latency).
  always_ff @(posedge clock) begin
    if (reset) begin
      linhas  <= ROWS_DARK;
      colunas <= '0;
    end else if (state_d == SCAN) begin
      linhas  <= row_drive;
      colunas <= colunas_in;
    end else begin
      linhas  <= ROWS_DARK;
      colunas <= '0;
    end
  end

endmodule

// File: tb/tb_controle_varredura_matriz.sv
// Testbench for controle_varredura_matriz (DIV_ROW=4, ROWS=7, FRAMES=4, DWELL=2).
// The stimulus queues hand-computed expectations tagged with a cycle number.
// A monitor compares them against the DUT outputs on the falling edge.
module tb_controle_varredura_matriz;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       hold;
  logic [4:0] colunas_in;
  logic [2:0] contador;
  logic [1:0] quadro_sel;
  logic [6:0] linhas;
  logic [4:0] colunas;
  logic       fim_quadro;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int pulses = 0;

  typedef struct {
    string      name;
    int         due;
    logic [2:0] cont;
    logic [1:0] q;
    logic [6:0] lin;
    logic [4:0] col;
    logic       fim;
    int         fc;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  assign colunas_in = {2'b0, contador} ^ {quadro_sel, 3'b0};

  always @(posedge clock) cyc <= cyc + 1;

  controle_varredura_matriz #(
    .DIV_ROW(4),
    .ROWS   (7),
    .FRAMES (4),
    .DWELL  (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .hold      (hold),
    .colunas_in(colunas_in),
    .contador  (contador),
    .quadro_sel(quadro_sel),
    .linhas    (linhas),
    .colunas   (colunas),
    .fim_quadro(fim_quadro)
  );

  task automatic expect_at(input string name, input int due, input logic [2:0] c,
                           input logic [1:0] q, input logic [6:0] lin,
                           input logic [4:0] col, input logic fim, input int fc);
    exp_t e;
    e.name = name; e.due = due; e.cont = c; e.q = q;
    e.lin = lin; e.col = col; e.fim = fim; e.fc = fc;
    sb.push_back(e);
  endtask

  // Advance to just after rising edge k.
  task automatic goto_cycle(input int k);
    while (cyc < k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: counts fim_quadro pulses and checks due expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (fim_quadro === 1'b1) pulses++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.due != cyc) begin
          n_bad++;
          $display("FAIL %s: check for cycle %0d reached only at cycle %0d", e.name, e.due, cyc);
        end else if ({contador, quadro_sel, linhas, colunas, fim_quadro} !==
                     {e.cont, e.q, e.lin, e.col, e.fim} || pulses != e.fc) begin
          n_bad++;
          $display("FAIL %s @%0d: got contador=%0d quadro_sel=%0d linhas=%h colunas=%h fim=%b pulses=%0d; expected contador=%0d quadro_sel=%0d linhas=%h colunas=%h fim=%b pulses=%0d",
                   e.name, cyc, contador, quadro_sel, linhas, colunas, fim_quadro, pulses,
                   e.cont, e.q, e.lin, e.col, e.fim, e.fc);
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: run still active at cycle %0d, expected end before 5000", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int last;
    reset  = 1'b1;
    enable = 1'b1;
    hold   = 1'b0;

    goto_cycle(3);
    expect_at("reset_state", 3, 3'd0, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    reset = 1'b0;

`ifdef MATRIZ_BLANK_EN
    expect_at("scan_entry",     4, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("row0_last",      7, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("blank_first",    8, 3'd1, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    expect_at("blank_second",   9, 3'd1, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    expect_at("after_blank",   10, 3'd1, 2'd0, 7'h7D, 5'h01, 1'b0, 0);
    expect_at("row1_steady",   11, 3'd1, 2'd0, 7'h7D, 5'h01, 1'b0, 0);
    expect_at("blank_row2",    12, 3'd2, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    goto_cycle(12);
    reset = 1'b1;
    expect_at("reset_in_blank", 13, 3'd0, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    goto_cycle(13);
    reset = 1'b0;
    expect_at("rescan",        14, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("blank_again",   18, 3'd1, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    goto_cycle(18);
    enable = 1'b0;
    expect_at("blank_disable", 19, 3'd1, 2'd0, 7'h7F, 5'h00, 1'b0, 0);
    goto_cycle(21);
    enable = 1'b1;
    expect_at("blank_reenable", 22, 3'd1, 2'd0, 7'h7D, 5'h01, 1'b0, 0);
    last = 26;
`else
    // Steady scan: SCAN entered at edge 4, one row step every 4 cycles.
    expect_at("scan_entry",      4, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("row0_last",       7, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("tick1",           8, 3'd1, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("row1",            9, 3'd1, 2'd0, 7'h7D, 5'h01, 1'b0, 0);
    expect_at("tick6",          28, 3'd6, 2'd0, 7'h5F, 5'h05, 1'b0, 0);
    expect_at("row6",           29, 3'd6, 2'd0, 7'h3F, 5'h06, 1'b0, 0);
    expect_at("wrap1",          32, 3'd0, 2'd0, 7'h3F, 5'h06, 1'b0, 0);
    expect_at("wrap1_row0",     33, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 0);
    expect_at("frame1",         60, 3'd0, 2'd1, 7'h3F, 5'h06, 1'b1, 1);
    expect_at("frame1_row0",    61, 3'd0, 2'd1, 7'h7E, 5'h08, 1'b0, 1);
    expect_at("frame3",        172, 3'd0, 2'd3, 7'h3F, 5'h16, 1'b1, 3);
    expect_at("frame_wrap",    228, 3'd0, 2'd0, 7'h3F, 5'h1E, 1'b1, 4);
    expect_at("frame_wrap_row",229, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 4);

    // Hold across four scan wraps (256, 284, 312, 340), release before 368.
    goto_cycle(229);
    hold = 1'b1;
    expect_at("hold_no_adv",   284, 3'd0, 2'd0, 7'h3F, 5'h06, 1'b0, 4);
    expect_at("hold_4scans",   340, 3'd0, 2'd0, 7'h3F, 5'h06, 1'b0, 4);
    goto_cycle(341);
    hold = 1'b0;
    expect_at("hold_pre_wrap", 367, 3'd6, 2'd0, 7'h3F, 5'h06, 1'b0, 4);
    expect_at("hold_release",  368, 3'd0, 2'd1, 7'h3F, 5'h06, 1'b1, 5);

    // Disable mid-row at contador=3, re-enable later.
    goto_cycle(381);
    expect_at("row3",          381, 3'd3, 2'd1, 7'h77, 5'h0B, 1'b0, 5);
    enable = 1'b0;
    expect_at("disable_dark",  382, 3'd3, 2'd1, 7'h7F, 5'h00, 1'b0, 5);
    goto_cycle(388);
    expect_at("idle_held",     388, 3'd3, 2'd1, 7'h7F, 5'h00, 1'b0, 5);
    enable = 1'b1;
    expect_at("reenable",      389, 3'd3, 2'd1, 7'h77, 5'h0B, 1'b0, 5);
    expect_at("reenable_pre",  392, 3'd3, 2'd1, 7'h77, 5'h0B, 1'b0, 5);
    expect_at("reenable_tick", 393, 3'd4, 2'd1, 7'h77, 5'h0B, 1'b0, 5);
    expect_at("row4",          394, 3'd4, 2'd1, 7'h6F, 5'h0C, 1'b0, 5);

    // Reset in the middle of a run.
    goto_cycle(398);
    reset = 1'b1;
    expect_at("reset_midrun",  399, 3'd0, 2'd0, 7'h7F, 5'h00, 1'b0, 5);
    goto_cycle(399);
    reset = 1'b0;
    expect_at("post_reset",    400, 3'd0, 2'd0, 7'h7E, 5'h00, 1'b0, 5);
    last = 405;
`endif

    goto_cycle(last);
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expectations never checked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
